// File: rtl/input_cond_pkg.sv
// Shared timing defaults and counter-width helpers
// for the pad input conditioner.
package input_cond_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000;
  localparam int unsigned DEF_LONG_CYCLES     = 100_000_000;

  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

  // Hold counter must reach both the long
  // threshold and the first repeat point.
  function automatic int unsigned hold_w(
    input int unsigned l,
    input int unsigned rd,
    input int unsigned rp
  );
    return cnt_w(max2(l, rd + rp) + 1);
  endfunction

endpackage

// File: rtl/input_cond_if.sv
// Pad-to-core bundle: raw pads in, conditioned
// level / pulse / flag vectors out.
interface input_cond_if #(
    parameter int N = 5
);

    logic [N-1:0] raw_i;
    logic [N-1:0] level_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;
    logic [N-1:0] long_o;

    modport master (
        output raw_i,
        input  level_o,
        input  press_o,
        input  release_o,
        input  long_o
    );

    modport slave (
        input  raw_i,
        output level_o,
        output press_o,
        output release_o,
        output long_o
    );

endinterface

// File: rtl/input_cond_channel.sv
// One conditioned channel: synchroniser, debounce,
// hold timing, auto-repeat and long-press flag.
module input_cond_channel
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic hold_long
);

    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int HW = hold_w(LONG_CYCLES,
                               REPEAT_DELAY,
                               REPEAT_PERIOD);
    localparam int RW = cnt_w(REPEAT_PERIOD);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = '1;
    localparam logic [HW-1:0] H_RD   = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] H_LONG = HW'(LONG_CYCLES);
    localparam logic [RW-1:0] R_LOAD = RW'(REPEAT_PERIOD - 1);

    logic          pin;
    logic          s1;
    logic          s2;
    logic          lvl;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic [RW-1:0] rcnt;
    logic          armed;
    logic          rep_hit;

    logic          level_q;
    logic          press_q;
    logic          rel_q;
    logic          long_q;

    assign pin = raw ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl  <= 1'b0;
            dcnt <= '0;
        end else if (s2 == lvl) begin
            dcnt <= '0;
        end else if (dcnt == D_LAST) begin
            lvl  <= ~lvl;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
        end else if (!lvl) begin
            hcnt <= '0;
        end else if (hcnt != H_MAX) begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // First repeat keys off the hold count; later ones
    // off rcnt, so hold saturation never stalls repeats.
    always_comb begin
        rep_hit = 1'b0;
        if (REPEAT_EN && lvl) begin
            rep_hit = armed ? (rcnt == '0)
                            : (hcnt == H_RD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            rcnt  <= '0;
        end else if (!lvl) begin
            armed <= 1'b0;
            rcnt  <= '0;
        end else if (rep_hit) begin
            armed <= 1'b1;
            rcnt  <= R_LOAD;
        end else if (armed) begin
            rcnt  <= rcnt - RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            level_q <= lvl;
            press_q <= (lvl & ~level_q) | rep_hit;
            rel_q   <= ~lvl & level_q;
            long_q  <= lvl && (hcnt >= H_LONG);
        end
    end

    assign level     = level_q;
    assign press     = press_q;
    assign rel       = rel_q;
    assign hold_long = long_q;

endmodule

// File: rtl/input_conditioner.sv
// N-channel pad conditioner: debounced levels, press /
// release pulses, auto-repeat and long-press flags.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned N               = 5,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter logic [N-1:0] REPEAT_MASK     = '0,
    parameter logic [N-1:0] ACTIVE_LOW_MASK = '0
) (
    input logic         clk,
    input logic         cpu_resetn,
    input_cond_if.slave io
);

    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] hold_long;

    for (genvar g = 0; g < N; g++) begin : g_ch
        input_cond_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_EN       (REPEAT_MASK[g]),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[g])
        ) u_ch (
            .clk       (clk),
            .rst_n     (cpu_resetn),
            .raw       (io.raw_i[g]),
            .level     (level[g]),
            .press     (press[g]),
            .rel       (rel[g]),
            .hold_long (hold_long[g])
        );
    end

    assign io.level_o   = level;
    assign io.press_o   = press;
    assign io.release_o = rel;
    assign io.long_o    = hold_long;

endmodule
